// File: rtl/bus_mux_pipelined.sv
// Registered bus multiplexer: encoded-select or round-robin source choice, valid/ready output stage.
// Optional error counter output err_count enabled by defining BUS_MUX_ERR_CNT_EN.
module bus_mux_pipelined #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_SRC   = 27,
  parameter int unsigned MODE      = 0,
  parameter int unsigned ZERO_IDLE = 1
) (
  input  logic                              clock,
  input  logic                              clear_n,
  input  logic [NUM_SRC*WIDTH-1:0]          src_data,
  input  logic [$clog2(NUM_SRC+1)-1:0]      select,
  input  logic                              sel_valid,
  output logic                              sel_ready,
  input  logic [NUM_SRC-1:0]                req,
  output logic [NUM_SRC-1:0]                grant,
  output logic [WIDTH-1:0]                  bus_out,
  output logic                              bus_valid,
  input  logic                              bus_ready,
  output logic [$clog2(NUM_SRC+1)-1:0]      bus_src,
  output logic                              sel_err
`ifdef BUS_MUX_ERR_CNT_EN
  ,
  output logic [7:0]                        err_count
`endif
);

  localparam int unsigned SEL_W = $clog2(NUM_SRC + 1);
  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(NUM_SRC);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SRC - 1);

  logic [WIDTH-1:0] src_arr [NUM_SRC];

  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             free_c;
  logic             found_c;
  logic [PTR_W-1:0] gidx_c;
  logic [WIDTH-1:0] gdata_c;
  logic [NUM_SRC-1:0] grant_c;
  logic             sel_hit_c;
  logic [WIDTH-1:0] sdata_c;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign src_arr[g] = src_data[g*WIDTH +: WIDTH];
  end

  assign free_c    = !valid_q || bus_ready;
  assign sel_ready = free_c;

  // Round-robin search: first pass covers indices at/above the pointer, second pass wraps to 0.
  always_comb begin
    found_c = 1'b0;
    gidx_c  = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!found_c && req[k] && (PTR_W'(k) >= rr_ptr_q)) begin
        found_c = 1'b1;
        gidx_c  = PTR_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!found_c && req[k]) begin
        found_c = 1'b1;
        gidx_c  = PTR_W'(k);
      end
    end
    grant_c = '0;
    gdata_c = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (found_c && (gidx_c == PTR_W'(k))) begin
        grant_c[k] = 1'b1;
        gdata_c    = src_arr[k];
      end
    end
  end

  assign grant = ((MODE == 1) && clear_n && free_c) ? grant_c : '0;

  // Encoded select decode (code 1 maps to source 0).
  always_comb begin
    sel_hit_c = (select != '0) && (select <= MAX_SEL);
    sdata_c   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (select == SEL_W'(k + 1)) sdata_c = src_arr[k];
    end
  end

  always_comb begin
    bus_out_d = bus_out_q;
    valid_d   = valid_q;
    src_d     = src_q;
    err_d     = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    if (free_c) begin
      valid_d = 1'b0;
      src_d   = '0;
      if (ZERO_IDLE != 0) bus_out_d = '0;
      if (MODE == 0) begin
        if (sel_valid && sel_hit_c) begin
          bus_out_d = sdata_c;
          valid_d   = 1'b1;
          src_d     = select;
        end else if (sel_valid && (select > MAX_SEL)) begin
          err_d = 1'b1;
        end
      end else if (found_c) begin
        bus_out_d = gdata_c;
        valid_d   = 1'b1;
        src_d     = SEL_W'(gidx_c) + SEL_W'(1);
        rr_ptr_d  = (gidx_c == LAST_IDX) ? '0 : gidx_c + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      bus_out_q <= '0;
      valid_q   <= 1'b0;
      src_q     <= '0;
      err_q     <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      bus_out_q <= bus_out_d;
      valid_q   <= valid_d;
      src_q     <= src_d;
      err_q     <= err_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign bus_out   = bus_out_q;
  assign bus_valid = valid_q;
  assign bus_src   = src_q;
  assign sel_err   = err_q;

`ifdef BUS_MUX_ERR_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Saturating count, stepping together with the sel_err pulse.
  always_comb begin
    cnt_d = cnt_q;
    if (err_d && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign err_count = cnt_q;
`endif

endmodule

// File: tb/tb_bus_mux_pipelined.sv
// Bench for bus_mux_pipelined: encoded-select instance (27 sources) and round-robin instance (4 sources).
module tb_bus_mux_pipelined;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  s;
  } exp_t;

  logic clock = 1'b0;
  logic clear_n;
  always #5 clock = ~clock;

  logic [27*32-1:0] a_src_data;
  logic [4:0]       a_select;
  logic             a_sel_valid, a_sel_ready, a_bus_valid, a_bus_ready, a_sel_err;
  logic [26:0]      a_req, a_grant;
  logic [31:0]      a_bus_out;
  logic [4:0]       a_bus_src;

  logic [4*32-1:0]  b_src_data;
  logic [2:0]       b_select;
  logic             b_sel_valid, b_sel_ready, b_bus_valid, b_bus_ready, b_sel_err;
  logic [3:0]       b_req, b_grant;
  logic [31:0]      b_bus_out;
  logic [2:0]       b_bus_src;

`ifdef BUS_MUX_ERR_CNT_EN
  logic [7:0] a_err_count, b_err_count;
`endif

  bus_mux_pipelined #(.WIDTH(32), .NUM_SRC(27), .MODE(0), .ZERO_IDLE(1)) u_a (
    .clock(clock), .clear_n(clear_n), .src_data(a_src_data), .select(a_select),
    .sel_valid(a_sel_valid), .sel_ready(a_sel_ready), .req(a_req), .grant(a_grant),
    .bus_out(a_bus_out), .bus_valid(a_bus_valid), .bus_ready(a_bus_ready),
    .bus_src(a_bus_src), .sel_err(a_sel_err)
`ifdef BUS_MUX_ERR_CNT_EN
    , .err_count(a_err_count)
`endif
  );

  bus_mux_pipelined #(.WIDTH(32), .NUM_SRC(4), .MODE(1), .ZERO_IDLE(1)) u_b (
    .clock(clock), .clear_n(clear_n), .src_data(b_src_data), .select(b_select),
    .sel_valid(b_sel_valid), .sel_ready(b_sel_ready), .req(b_req), .grant(b_grant),
    .bus_out(b_bus_out), .bus_valid(b_bus_valid), .bus_ready(b_bus_ready),
    .bus_src(b_bus_src), .sel_err(b_sel_err)
`ifdef BUS_MUX_ERR_CNT_EN
    , .err_count(b_err_count)
`endif
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitors: every word the consumer takes must match the oldest expectation.
  always @(negedge clock) begin
    if (clear_n && a_bus_valid && a_bus_ready) begin
      if (qa.size() == 0) chk("a_unexpected_word", 64'(a_bus_out), 64'hDEAD);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_bus_out", 64'(a_bus_out), 64'(e.d));
        chk("a_bus_src", 64'(a_bus_src), 64'(e.s));
      end
    end
  end

  always @(negedge clock) begin
    if (clear_n && b_bus_valid && b_bus_ready) begin
      if (qb.size() == 0) chk("b_unexpected_word", 64'(b_bus_out), 64'hDEAD);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_bus_out", 64'(b_bus_out), 64'(e.d));
        chk("b_bus_src", 64'({2'b00, b_bus_src}), 64'(e.s));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ks [6];
    ks = '{0, 1, 3, 0, 1, 3};
    for (int i = 0; i < 27; i++) a_src_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 4; i++)  b_src_data[i*32 +: 32] = 32'hB000_0000 + 32'(i);
    clear_n = 1'b0;
    a_select = '0; a_sel_valid = 1'b0; a_req = '0; a_bus_ready = 1'b1;
    b_select = '0; b_sel_valid = 1'b0; b_req = 4'b1111; b_bus_ready = 1'b1;
    step(); step();
    chk("rst_a_bus_out", 64'(a_bus_out), 64'h0);
    chk("rst_a_valid", 64'(a_bus_valid), 64'h0);
    chk("rst_a_src", 64'(a_bus_src), 64'h0);
    chk("rst_a_err", 64'(a_sel_err), 64'h0);
    chk("rst_b_grant", 64'(b_grant), 64'h0);
`ifdef BUS_MUX_ERR_CNT_EN
    chk("rst_err_count", 64'(a_err_count), 64'h0);
`endif
    b_req = '0;
    clear_n = 1'b1;
    step();

    // Encoded select: first, last, zero, out of range.
    a_sel_valid = 1'b1; a_select = 5'd1;
    qa.push_back('{d: 32'hA000_0000, s: 5'd1});
    step();
    chk("sel1_valid", 64'(a_bus_valid), 64'h1);
    a_select = 5'd27;
    qa.push_back('{d: 32'hA000_001A, s: 5'd27});
    step();
    chk("sel27_out", 64'(a_bus_out), 64'hA000_001A);
    a_select = 5'd0;
    step();
    chk("sel0_valid", 64'(a_bus_valid), 64'h0);
    chk("sel0_out", 64'(a_bus_out), 64'h0);
    chk("sel0_err", 64'(a_sel_err), 64'h0);
    a_select = 5'd28;
    step();
    chk("sel28_err", 64'(a_sel_err), 64'h1);
    chk("sel28_valid", 64'(a_bus_valid), 64'h0);
    a_sel_valid = 1'b0;
    step();
    chk("sel28_err_pulse_end", 64'(a_sel_err), 64'h0);
    chk("idle_sel_ready", 64'(a_sel_ready), 64'h1);
`ifdef BUS_MUX_ERR_CNT_EN
    chk("err_count_one", 64'(a_err_count), 64'h1);
    a_sel_valid = 1'b1; a_select = 5'd31;
    for (int i = 0; i < 300; i++) step();
    a_sel_valid = 1'b0;
    step(); step();
    chk("err_count_sat", 64'(a_err_count), 64'hFF);
`endif

    // Stall: word 3 held while select changes to 9, then released.
    a_sel_valid = 1'b1; a_select = 5'd4;
    qa.push_back('{d: 32'hA000_0003, s: 5'd4});
    step();
    a_bus_ready = 1'b0; a_select = 5'd9;
    #1;
    chk("stall_sel_ready", 64'(a_sel_ready), 64'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_hold_out", 64'(a_bus_out), 64'hA000_0003);
      chk("stall_hold_valid", 64'(a_bus_valid), 64'h1);
      chk("stall_no_err", 64'(a_sel_err), 64'h0);
    end
    a_bus_ready = 1'b1;
    qa.push_back('{d: 32'hA000_0008, s: 5'd9});
    step();
    chk("unstall_out", 64'(a_bus_out), 64'hA000_0008);
    a_sel_valid = 1'b0;
    step(); step();

    // Round robin with req 1011 held.
    b_req = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_grant", 64'(b_grant), 64'(4'b0001 << ks[i]));
      qb.push_back('{d: 32'hB000_0000 + 32'(ks[i]), s: 5'(ks[i] + 1)});
      step();
    end
    b_req = 4'b0000;
    #1;
    chk("rr_grant_none", 64'(b_grant), 64'h0);
    step();
    chk("rr_idle_valid", 64'(b_bus_valid), 64'h0);

    // Load a word, stall, then reset mid-stall.
    b_req = 4'b0100;
    qb.push_back('{d: 32'hB000_0002, s: 5'd3});
    step();
    b_bus_ready = 1'b0; b_req = 4'b1111;
    #1;
    chk("stall_grant_zero", 64'(b_grant), 64'h0);
    step();
    chk("b_stall_valid", 64'(b_bus_valid), 64'h1);
    #2 clear_n = 1'b0;
    #1;
    chk("arst_b_out", 64'(b_bus_out), 64'h0);
    chk("arst_b_valid", 64'(b_bus_valid), 64'h0);
    chk("arst_b_src", 64'(b_bus_src), 64'h0);
    chk("arst_b_grant", 64'(b_grant), 64'h0);
    qb.delete();
    qb.push_back('{d: 32'hB000_0002, s: 5'd3});
    qb.delete();
    step();
    clear_n = 1'b1; b_bus_ready = 1'b1;
    #1;
    chk("post_rst_grant", 64'(b_grant), 64'h1);
    qb.push_back('{d: 32'hB000_0000, s: 5'd1});
    step();
    b_req = 4'b0000;
    step(); step();

    chk("qa_drained", 64'(qa.size()), 64'h0);
    chk("qb_drained", 64'(qb.size()), 64'h0);
    chk("b_never_err", 64'(b_sel_err), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_mux_pipelined.md
Name: bus_mux_pipelined

Overview:
Parametrised successor to the CPU datapath bus multiplexer. It selects one of NUM_SRC WIDTH-bit sources onto the internal bus and registers the result.
- Selection is either by encoded select (1-based: code 1 = source 0, code 0 = no driver) or by round-robin arbitration over per-source requests.
- The output stage carries a valid/ready handshake, so a stalled consumer holds the bus word stable.
- The block sits between register-file/special-register outputs and the bus consumers (Y, MAR, MDR, register inputs).

Parameters:
- WIDTH, 32, bus and source data width in bits.
- NUM_SRC, 27, number of sources (1..31 when MODE=0; 2..64 when MODE=1).
- MODE, 0, 0 = encoded select; 1 = round-robin arbitration on req.
- ZERO_IDLE, 1, 1 = bus_out forced to 0 when no word is valid; 0 = bus_out holds its last value.
- Derived localparam: SEL_W = $clog2(NUM_SRC+1).

Ports:
- clock  input  1  rising-edge clock.
- clear_n  input  1  asynchronous active-low reset.
- src_data  input  NUM_SRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- select  input  SEL_W  encoded select, 1-based (MODE=0 only; ignored when MODE=1).
- sel_valid  input  1  select is presented this cycle (MODE=0).
- sel_ready  output  1  output stage can accept; combinational: !bus_valid || bus_ready.
- req  input  NUM_SRC  per-source bus requests (MODE=1; ignored when MODE=0).
- grant  output  NUM_SRC  one-hot combinational grant (MODE=1); all zero when MODE=0.
- bus_out  output  WIDTH  registered bus word.
- bus_valid  output  1  bus_out holds a valid word.
- bus_ready  input  1  consumer accepts bus_out this cycle.
- bus_src  output  SEL_W  1-based code of the source currently on bus_out; 0 when none.
- sel_err  output  1  one-cycle pulse on an accepted out-of-range select.

Behaviour:
- Reset (async, clear_n=0): bus_out=0, bus_valid=0, bus_src=0, sel_err=0, rr_ptr=0. grant is 0 while in reset. Release is synchronous to the next clock edge.
- Stage-free condition: free = !bus_valid || bus_ready. Registers update only when free; otherwise bus_out, bus_valid and bus_src hold and grant=0.
- Latency: 1 cycle from accepted select/grant to bus_valid=1 with the data.
- MODE=0, free and sel_valid:
  - select in 1..NUM_SRC: bus_out<=src[select-1], bus_valid<=1, bus_src<=select.
  - select=0: bus_valid<=0, bus_src<=0, bus_out<=0 if ZERO_IDLE else hold. No error.
  - select>NUM_SRC: same as select=0, plus sel_err<=1 for one cycle.
- MODE=0, free and !sel_valid: bus_valid<=0, bus_src<=0, bus_out as the idle rule.
- MODE=0, sel_valid while not free: not accepted; the requester must hold select until sel_ready=1.
- MODE=1 arbitration:
  - When free, grant = one-hot of the first asserted req at index >= rr_ptr, searching upward and wrapping to 0.
  - On grant of index k: bus_out<=src[k], bus_valid<=1, bus_src<=k+1, rr_ptr<=(k+1) mod NUM_SRC.
  - No req: bus_valid<=0, bus_src<=0, idle rule applies, rr_ptr unchanged.
  - A requester must hold req until it sees grant. A req dropped before grant is simply not served.
- Back-to-back: when bus_valid=1 and bus_ready=1, a new word loads in the same cycle, giving full throughput.
- sel_err is 0 in every cycle not described above; it never asserts in MODE=1.
- Reset mid-stall: the pending word is discarded and rr_ptr returns to 0.

Optional Feature:
- Macro: BUS_MUX_ERR_CNT_EN.
- Defined: adds output err_count [7:0]. It resets to 0, increments on each sel_err pulse and saturates at 255.
- Undefined: the port and its counter do not exist. sel_err is unaffected either way.

Test Plan:
- MODE=0, NUM_SRC=27, src i = 32'hA000_0000+i, sel_valid=1, select=5'd1, bus_ready=1 -> next cycle bus_out=32'hA000_0000, bus_valid=1, bus_src=1.
- MODE=0, select=5'd27 then 5'd0 -> bus_out=32'hA000_001A, bus_src=27; then bus_valid=0, bus_out=0 (ZERO_IDLE=1), sel_err stays 0.
- MODE=0, select=5'd28 -> sel_err pulses for exactly one cycle, bus_valid=0; with BUS_MUX_ERR_CNT_EN, err_count goes 0->1. After 300 such selects, err_count=255.
- Stall: load source 3 (select=4), then bus_ready=0 for 4 cycles while select changes to 9 -> bus_out=32'hA000_0003 held, sel_ready=0. With select still 9, raise bus_ready -> next cycle bus_out=32'hA000_0008.
- MODE=1, NUM_SRC=4, req=4'b1011 held, bus_ready=1 -> grants in order 0,1,3,0,1,3; bus_src sequence 1,2,4,1,2,4.
- Assert clear_n=0 mid-stall with bus_valid=1 -> bus_out=0, bus_valid=0 and bus_src=0 immediately (no clock edge needed). After release with req=4'b1111, the first grant is index 0.
